decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I decode stage between fetch and execute.
- Drives the register file's synchronous read addresses, `rs1i`/`rs2i`, and captures the decoded instruction in the same edge.
- One cycle later, merges register-file read data with write-back bypass and the x0 rule, then presents operands plus control to execute.
- Valid/ready handshake on both sides; flush input for branch redirect.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  kill held and incoming instruction.
- rs1i  out  RA_W  register file read address 1.
- rs2i  out  RA_W  register file read address 2.
- read_data1  in  XLEN  register file data, valid one edge after address sampled.
- read_data2  in  XLEN  as above.
- wb_we  in  1  write-back write enable (same signal feeding register file reg_write).
- wb_rd  in  RA_W  write-back destination.
- wb_data  in  XLEN  write-back data.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  pc of decoded instruction.
- out_op1  out  XLEN  resolved rs1 value.
- out_op2  out  XLEN  resolved rs2 value.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd  out  RA_W  destination.
- out_rd_we  out  1  writes rd; forced 0 when rd==0.
- out_funct3  out  3  funct3 passthrough.
- out_alu_op  out  4  ALU operation code (decode_pkg).
- out_use_imm  out  1  op2 source is immediate.
- out_class  out  4  LOAD/STORE/BRANCH/JAL/JALR/LUI/AUIPC/ALU/SYSTEM (decode_pkg).
- out_illegal  out  1  unrecognised encoding.

Behaviour:
- Reset (async, immediate):
  - out_valid=0.
  - All registered outputs, held instruction and bypass flags cleared to 0.
- in_ready = !flush && (!out_valid || out_ready); accept = in_valid && in_ready.
- Address mux: rs1i/rs2i = accept ? in_instr[19:15]/[24:20] : held instr fields. Addresses therefore stay stable during a stall, because the register file re-reads every edge.
- Latency:
  - Instruction accepted at edge E appears with out_valid=1 after E.
  - Operands resolve combinationally from read_data sampled at E.
- Bypass, per operand n, updated at every edge:
  - bypn <= wb_we && wb_rd==rsni && wb_rd!=0.
  - bypdn <= wb_data.
  - Covers the register file returning the old value when read and written in the same edge.
- Operand: out_opn = (held rsn==0) ? 0 : bypn ? bypdn : read_datan. x0 is forced to zero regardless of register file contents.
- Immediate generation by format:
  - I-type: instr[31:20].
  - S-type: {31:25, 11:7}.
  - B-type: {31, 7, 30:25, 11:8, 0}.
  - U-type: {31:12, 12'b0}.
  - J-type: {31, 19:12, 20, 30:21, 0}.
  - All sign-extended from bit 31.
  - R-type imm = 0.
- out_illegal=1 for:
  - unknown opcode;
  - funct7 other than 0x00/0x20 on OP, or 0x20 with funct3 not in {0,5};
  - illegal funct3 on LOAD/STORE/BRANCH.
  - An illegal instruction still flows with out_valid=1 and out_rd_we=0.
- Handshake:
  - out_valid <= accept ? 1 : (out_ready ? 0 : out_valid).
  - Outputs hold stable while out_valid && !out_ready.
- Flush:
  - out_valid <= 0 at the next edge.
  - in_ready=0 that cycle, so a concurrent in_valid is not accepted.
  - Bypass flags still update.
- Simultaneous out_ready and in_valid: back-to-back transfer, no bubble.

Optional Feature:
- DECODE_RV32M_EN defined: OP with funct7=0x01 decodes as MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Uses out_alu_op codes 8-15, class ALU, legal.
- Undefined: funct7=0x01 gives out_illegal=1.

Decomposition:
- decode_pkg holds:
  - opcode localparams (LOAD=0x03, OPIMM=0x13, AUIPC=0x17, STORE=0x23, OP=0x33, LUI=0x37, BRANCH=0x63, JALR=0x67, JAL=0x6F, SYSTEM=0x73);
  - alu_op codes (ADD=0 … AND=7, M ops 8-15);
  - out_class codes.
- One combinational sub-module, imm_gen (instr in, imm out), is natural.

Test Plan:
- 0x00500093 (addi x1,x0,5) accepted, out_ready=1 → next cycle out_valid=1, out_imm=5, out_op1=0 even with read_data1=0xDEADBEEF, out_rd=1, out_rd_we=1, out_use_imm=1.
- 0xFE20AC23 (sw x2,-8(x1)) → out_imm=0xFFFFFFF8, class STORE, out_rd_we=0; 0x123451B7 (lui x3) → out_imm=0x12345000.
- Bypass: accept add using rs1=5 in the same edge as wb_we=1, wb_rd=5, wb_data=0x11, with stale read_data1=0x99 → out_op1=0x11; same stimulus with wb_rd=0 → out_op1=0x99.
- Stall:
  - out_ready=0 for 3 cycles → outputs and rs1i/rs2i stable, in_ready=0.
  - A write to rs1 mid-stall updates out_op1 via bypass, then via read_data.
- flush asserted with out_valid=1 and in_valid=1 → out_valid=0 next cycle, incoming instruction dropped; rst mid-stall → out_valid=0 immediately.
- 0x027302B3 (mul x5,x6,x7) → legal with out_alu_op=8 when DECODE_RV32M_EN is defined, out_illegal=1 otherwise; opcode 0x7F → out_illegal=1.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared constants for the RV32I decode stage: major opcodes,
//               ALU operation codes, instruction class codes, and a helper
//               that checks funct3 legality for memory and branch opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    // ALU operation codes. The base set is indexed by funct3 so OP/OP-IMM
    // map directly; the add/sub and logical/arithmetic right-shift variants
    // are told apart by execute from funct7 (OP) or imm[10] (OP-IMM).
    // Multiply/divide ops occupy 8-15 in funct3 order.
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SLL    = 4'd1;
    localparam logic [3:0] ALU_SLT    = 4'd2;
    localparam logic [3:0] ALU_SLTU   = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SRL    = 4'd5;
    localparam logic [3:0] ALU_OR     = 4'd6;
    localparam logic [3:0] ALU_AND    = 4'd7;
    localparam logic [3:0] ALU_MUL    = 4'd8;
    localparam logic [3:0] ALU_MULH   = 4'd9;
    localparam logic [3:0] ALU_MULHSU = 4'd10;
    localparam logic [3:0] ALU_MULHU  = 4'd11;
    localparam logic [3:0] ALU_DIV    = 4'd12;
    localparam logic [3:0] ALU_DIVU   = 4'd13;
    localparam logic [3:0] ALU_REM    = 4'd14;
    localparam logic [3:0] ALU_REMU   = 4'd15;

    // Instruction class codes
    localparam logic [3:0] CLS_LOAD   = 4'd0;
    localparam logic [3:0] CLS_STORE  = 4'd1;
    localparam logic [3:0] CLS_BRANCH = 4'd2;
    localparam logic [3:0] CLS_JAL    = 4'd3;
    localparam logic [3:0] CLS_JALR   = 4'd4;
    localparam logic [3:0] CLS_LUI    = 4'd5;
    localparam logic [3:0] CLS_AUIPC  = 4'd6;
    localparam logic [3:0] CLS_ALU    = 4'd7;
    localparam logic [3:0] CLS_SYSTEM = 4'd8;

    // funct3 legality for opcodes with sparse funct3 maps; other opcodes
    // are reported legal here and checked elsewhere if needed.
    function automatic logic funct3_legal(input logic [6:0] opc,
                                          input logic [2:0] f3);
        logic ok;
        ok = 1'b1;
        case (opc)
            OPC_LOAD:   ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            OPC_STORE:  ok = (f3 <= 3'd2);
            OPC_BRANCH: ok = (f3 != 3'd2) && (f3 != 3'd3);
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational immediate generator. Selects the I/S/B/U/J
//               format from the opcode and sign-extends from instr[31].
//               R-type and unknown opcodes yield zero.
// Ports       : instr (in, 32)  instruction word
//               imm   (out, 32) sign-extended immediate
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode stage between fetch and execute. Drives the
//               register file's synchronous read addresses, registers the
//               decoded instruction on the same edge, then resolves operands
//               from register-file data, a write-back bypass and the x0 rule.
//               Optional macro DECODE_RV32M_EN enables the RV32M
//               multiply/divide encodings (funct7=0x01 on OP).
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready/in_instr/in_pc   fetch side handshake
//               flush                              kill held + incoming instr
//               rs1i/rs2i, read_data1/2            register-file read port
//               wb_we/wb_rd/wb_data                write-back bypass source
//               out_valid/out_ready + out_*        execute side
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [RA_W-1:0] rs1i,
    output logic [RA_W-1:0] rs2i,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [RA_W-1:0] out_rd,
    output logic            out_rd_we,
    output logic [2:0]      out_funct3,
    output logic [3:0]      out_alu_op,
    output logic            out_use_imm,
    output logic [3:0]      out_class,
    output logic            out_illegal
);

    logic            accept;
    logic [RA_W-1:0] held_rs1;
    logic [RA_W-1:0] held_rs2;
    logic            byp1;
    logic            byp2;
    logic [XLEN-1:0] bypd1;
    logic [XLEN-1:0] bypd2;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RA_W-1:0] dec_rd;
    logic [31:0]     dec_imm;
    logic [3:0]      dec_class;
    logic [3:0]      dec_alu_op;
    logic            dec_use_imm;
    logic            dec_writes;
    logic            dec_illegal;
    logic            dec_rd_we;

    // ------------------------------------------------------------------
    // Handshake and register-file address mux. While stalled the held
    // fields keep driving the addresses so the per-edge re-read returns
    // the same registers.
    // ------------------------------------------------------------------
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign rs1i     = accept ? in_instr[19:15] : held_rs1;
    assign rs2i     = accept ? in_instr[24:20] : held_rs2;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign dec_rd = in_instr[11:7];

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (dec_imm)
    );

    always_comb begin
        dec_class   = CLS_ALU;
        dec_alu_op  = ALU_ADD;
        dec_use_imm = 1'b1;
        dec_writes  = 1'b0;
        dec_illegal = !funct3_legal(opcode, funct3);
        case (opcode)
            OPC_LOAD: begin
                dec_class  = CLS_LOAD;
                dec_writes = 1'b1;
            end
            OPC_STORE: begin
                dec_class = CLS_STORE;
            end
            OPC_BRANCH: begin
                dec_class   = CLS_BRANCH;
                dec_use_imm = 1'b0;
            end
            OPC_JAL: begin
                dec_class  = CLS_JAL;
                dec_writes = 1'b1;
            end
            OPC_JALR: begin
                dec_class  = CLS_JALR;
                dec_writes = 1'b1;
            end
            OPC_LUI: begin
                dec_class  = CLS_LUI;
                dec_writes = 1'b1;
            end
            OPC_AUIPC: begin
                dec_class  = CLS_AUIPC;
                dec_writes = 1'b1;
            end
            OPC_OPIMM: begin
                dec_alu_op = {1'b0, funct3};
                dec_writes = 1'b1;
            end
            OPC_OP: begin
                dec_alu_op  = {1'b0, funct3};
                dec_use_imm = 1'b0;
                dec_writes  = 1'b1;
                case (funct7)
                    7'h00:   dec_illegal = 1'b0;
                    // Only SUB (funct3=0) and SRA (funct3=5) use the alternate encoding
                    7'h20:   dec_illegal = (funct3 != 3'd0) && (funct3 != 3'd5);
`ifdef DECODE_RV32M_EN
                    7'h01:   dec_alu_op  = {1'b1, funct3};
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                dec_class = CLS_SYSTEM;
            end
            default: begin
                dec_use_imm = 1'b0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // x0 is never written, and an illegal instruction must not write anything
    assign dec_rd_we = dec_writes && !dec_illegal && (dec_rd != '0);

    // ------------------------------------------------------------------
    // Pipeline register, held fields and bypass capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_funct3  <= '0;
            out_alu_op  <= '0;
            out_use_imm <= 1'b0;
            out_class   <= '0;
            out_illegal <= 1'b0;
            held_rs1    <= '0;
            held_rs2    <= '0;
            byp1        <= 1'b0;
            byp2        <= 1'b0;
            bypd1       <= '0;
            bypd2       <= '0;
        end else begin
            // The register file returns the pre-write value when read and
            // written on the same edge; remember the write so it wins.
            byp1  <= wb_we && (wb_rd == rs1i) && (wb_rd != '0);
            byp2  <= wb_we && (wb_rd == rs2i) && (wb_rd != '0);
            bypd1 <= wb_data;
            bypd2 <= wb_data;

            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_imm     <= dec_imm;
                out_rd      <= dec_rd;
                out_rd_we   <= dec_rd_we;
                out_funct3  <= funct3;
                out_alu_op  <= dec_alu_op;
                out_use_imm <= dec_use_imm;
                out_class   <= dec_class;
                out_illegal <= dec_illegal;
                held_rs1    <= in_instr[19:15];
                held_rs2    <= in_instr[24:20];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand resolution
    // ------------------------------------------------------------------
    assign out_op1 = (held_rs1 == '0) ? '0 : (byp1 ? bypd1 : read_data1);
    assign out_op2 = (held_rs2 == '0) ? '0 : (byp2 ? bypd2 : read_data2);

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage. Inputs change
//               1 time unit after the rising edge; outputs are sampled there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic [4:0]  rs1i;
    logic [4:0]  rs2i;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [2:0]  out_funct3;
    logic [3:0]  out_alu_op;
    logic        out_use_imm;
    logic [3:0]  out_class;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    decode_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .rs1i        (rs1i),
        .rs2i        (rs2i),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_imm     (out_imm),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_funct3  (out_funct3),
        .out_alu_op  (out_alu_op),
        .out_use_imm (out_use_imm),
        .out_class   (out_class),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        read_data1 = '0; read_data2 = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        out_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_rd_we", {31'b0, out_rd_we}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        // addi x1,x0,5
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
        #1;
        chk("addi_rs1i", {27'b0, rs1i}, 32'd0);
        step();
        in_valid = 1'b0; read_data1 = 32'hDEADBEEF;
        #1;
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_op1_x0", out_op1, 32'd0);
        chk("addi_rd", {27'b0, out_rd}, 32'd1);
        chk("addi_rd_we", {31'b0, out_rd_we}, 32'd1);
        chk("addi_use_imm", {31'b0, out_use_imm}, 32'd1);
        chk("addi_class", {28'b0, out_class}, 32'd7);
        chk("addi_pc", out_pc, 32'h100);

        // sw x2,-8(x1)
        in_valid = 1'b1; in_instr = 32'hFE20AC23; in_pc = 32'h104;
        step();
        chk("sw_imm", out_imm, 32'hFFFFFFF8);
        chk("sw_class", {28'b0, out_class}, 32'd1);
        chk("sw_rd_we", {31'b0, out_rd_we}, 32'd0);
        chk("sw_funct3", {29'b0, out_funct3}, 32'd2);

        // lui x3 back-to-back, no bubble
        in_instr = 32'h123451B7; in_pc = 32'h108;
        step();
        chk("lui_valid", {31'b0, out_valid}, 32'd1);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd", {27'b0, out_rd}, 32'd3);
        chk("lui_class", {28'b0, out_class}, 32'd5);
        chk("lui_pc", out_pc, 32'h108);

        // add x6,x5,x0 with same-edge write-back to x5
        in_instr = 32'h00028333; in_pc = 32'h10C;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h11;
        #1;
        chk("byp_rs1i", {27'b0, rs1i}, 32'd5);
        step();
        wb_we = 1'b0; in_valid = 1'b0; read_data1 = 32'h99; read_data2 = 32'h77;
        #1;
        chk("byp_op1", out_op1, 32'h11);
        chk("byp_op2_x0", out_op2, 32'd0);
        chk("add_use_imm", {31'b0, out_use_imm}, 32'd0);

        // Same stimulus, write-back to x0 must not bypass
        in_valid = 1'b1; in_pc = 32'h110;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h11;
        step();
        wb_we = 1'b0; read_data1 = 32'h99;
        #1;
        chk("nobyp_op1", out_op1, 32'h99);

        // Stall for three cycles with another instruction offered
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123451B7; in_pc = 32'h200;
        #1;
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_rs1i", {27'b0, rs1i}, 32'd5);
        step();
        chk("stall1_pc", out_pc, 32'h110);
        chk("stall1_op1", out_op1, 32'h99);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        step();
        wb_we = 1'b0;
        #1;
        chk("stall2_op1_byp", out_op1, 32'h55);
        chk("stall2_rd", {27'b0, out_rd}, 32'd6);
        step();
        read_data1 = 32'h55;
        #1;
        chk("stall3_op1_rf", out_op1, 32'h55);
        chk("stall3_valid", {31'b0, out_valid}, 32'd1);
        chk("stall3_rs1i", {27'b0, rs1i}, 32'd5);
        chk("stall3_pc", out_pc, 32'h110);

        // Flush with held instruction and incoming instruction
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_pc_kept", out_pc, 32'h110);

        // Reset in the middle of a stall
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h300; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_pc", out_pc, 32'd0);
        rst = 1'b0;

        // mul x5,x6,x7
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h027302B3; in_pc = 32'h304;
        step();
        chk("mul_rd", {27'b0, out_rd}, 32'd5);
`ifdef DECODE_RV32M_EN
        chk("mul_illegal", {31'b0, out_illegal}, 32'd0);
        chk("mul_alu_op", {28'b0, out_alu_op}, 32'd8);
        chk("mul_rd_we", {31'b0, out_rd_we}, 32'd1);
`else
        chk("mul_illegal", {31'b0, out_illegal}, 32'd1);
        chk("mul_rd_we", {31'b0, out_rd_we}, 32'd0);
`endif

        // Unknown opcode 0x7F with rd=6: flows but never writes
        in_instr = 32'h0000037F; in_pc = 32'h308;
        step();
        chk("unk_illegal", {31'b0, out_illegal}, 32'd1);
        chk("unk_valid", {31'b0, out_valid}, 32'd1);
        chk("unk_rd_we", {31'b0, out_rd_we}, 32'd0);

        // beq x0,x0,+8
        in_instr = 32'h00000463; in_pc = 32'h30C;
        step();
        chk("beq_imm", out_imm, 32'd8);
        chk("beq_class", {28'b0, out_class}, 32'd2);
        chk("beq_illegal", {31'b0, out_illegal}, 32'd0);

        // Branch with funct3=2 is illegal
        in_instr = 32'h00002463; in_pc = 32'h310;
        step();
        chk("br_f3_illegal", {31'b0, out_illegal}, 32'd1);

        // Drain
        in_valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
